dma_burst_writer: RTL and testbench
===================================

Name: dma_burst_writer

Overview:
- Single-clock packet-to-burst bridge between the stream mux and the Avalon-MM TXS write port of the PCIe hard IP.
- Accepts packets of up to 8 consecutive 128-bit words from the mux (dv per word, de on the last word, daddr per packet) and buffers up to 2 packets.
- Replays each buffered packet as one Avalon-MM write burst, honouring txs_waitrequest.

Parameters:
- DW, 128: data word width; must equal the txs_writedata width.
- AW, 23: byte-address width; must equal the txs_address width.
- BURST, 8: maximum words per packet and burst.
- PKTS, 2: number of packets the block can buffer.

Ports:
- c  in  1  clock; all logic in this single domain.
- rst  in  1  asynchronous active-high reset.
- d  in  128  packet data word.
- dv  in  1  d is valid this cycle.
- de  in  1  d is the last word of the packet; qualified by dv.
- daddr  in  23  burst start byte address; sampled with the first dv of each packet.
- ready  out  1  block can accept one complete packet starting next cycle.
- txs_write  out  1  Avalon write request.
- txs_writedata  out  128  Avalon write data.
- txs_burstcount  out  6  burst length in words (1..8).
- txs_address  out  23  burst start byte address.
- txs_waitrequest  in  1  slave stall.

Behaviour:
Reset (async, rst=1):
- Buffers empty; rx_cnt=0; pkt_count=0.
- txs_write=0; txs_writedata=0; txs_address=0; txs_burstcount=0.
- ready=1 as soon as rst deasserts.

Receive side:
- rx_cnt counts words of the packet currently being received.
- Every cycle with dv=1 writes d into the word buffer and increments rx_cnt.
- On the first word of a packet, daddr is latched into the per-packet descriptor.
- A packet closes on dv&de, or automatically on the 8th word even without de.
- When a packet closes:
  - its descriptor {address, length=rx_cnt+1} is pushed;
  - pkt_count increments at the same edge;
  - rx_cnt returns to 0.
- ready = (pkt_count + (rx_cnt!=0)) < PKTS.
  - ready is combinational from registered state, with no input-to-output path.
  - It therefore drops the cycle after a first word arrives that fills the last slot.
- dv while ready was low at the packet's first word is a protocol violation:
  - the word is discarded;
  - stored packets are not corrupted.
- The upstream mux waits for ready=1 and then sends 8 back-to-back words, addresses stepping +0x80 per packet. The block must sustain this with zero gaps.

Transmit state machine:
- IDLE:
  - If pkt_count>0, load the head descriptor and go to BURST.
  - Drive txs_write=1, txs_address=descriptor address, txs_burstcount=length, txs_writedata=first word.
- BURST:
  - A beat completes on txs_write & ~txs_waitrequest.
  - On each beat, present the next word on the following cycle.
  - address and burstcount are held constant for the whole burst.
  - While txs_waitrequest=1, all txs_* outputs hold unchanged.
  - On the last beat, pop the descriptor and decrement pkt_count.
  - Then either go straight to the next burst (pkt_count>0 after pop, back-to-back with no idle cycle) or return to IDLE with txs_write=0.
- Simultaneous packet close and burst completion in one cycle: pkt_count is net unchanged.
- Reset mid-burst: txs_write drops immediately and all buffered data is lost.

Decomposition:
- Shared package dma_pkg holds:
  - constants DMA_DW=128, DMA_AW=23, DMA_BURST=8;
  - the descriptor struct {addr[22:0], len[3:0]};
  - the tx state enum {IDLE, BURST}.
- One natural sub-module: sync_fifo, a parameterised single-clock show-ahead FIFO with async reset. It is instantiated twice:
  - word buffer: 16 words of 128 bits;
  - descriptor queue: 2 entries.

Test Plan:
- Reset then idle: ready=1, txs_write=0 for 20 cycles.
- One 8-word packet at daddr=0x10000, data 1..8, txs_waitrequest=0 -> exactly 8 write beats; burstcount=8, address=0x10000 constant; data 1..8 in order.
- Two packets back-to-back (0x10000, then 0x10080) with txs_waitrequest=1 held for 40 cycles:
  - ready=0 after the second packet's first word;
  - after release, 16 beats with no idle cycle between the bursts;
  - ready returns to 1 after the first burst completes.
- Random txs_waitrequest (50%) over 64 packets -> every word delivered exactly once, in order; address/burstcount stable within each burst.
- Short packet: 3 words with de on the 3rd at 0x20000 -> one burst with burstcount=3 and 3 beats.
- rst asserted mid-burst -> txs_write=0 asynchronously; after release pkt_count=0 and ready=1; a new packet bursts correctly.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared constants and types for the packet-to-burst DMA writer.
package dma_pkg;
    localparam int DMA_DW    = 128;
    localparam int DMA_AW    = 23;
    localparam int DMA_BURST = 8;

    // One buffered packet: burst start address and word count (1..8).
    typedef struct packed {
        logic [22:0] addr;
        logic [3:0]  len;
    } desc_t;

    typedef enum logic {TX_IDLE, TX_BURST} tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rdata always shows the head entry.
// A pop on an empty FIFO is allowed only together with a push; the caller
// forwards wdata in that case, and the pointers stay consistent.
// Producers are flow-controlled upstream, so there is no full flag.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   cnt_q;

    assign rdata = mem_q[rptr_q];
    assign empty = (cnt_q == '0);

    // Storage array, no reset needed: contents are only read once written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata;
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end
endmodule

// File: rtl/dma_burst_writer.sv
// Store-and-forward bridge: buffers up to PKTS packets from the stream mux
// and replays each one as an Avalon-MM write burst.
module dma_burst_writer
    import dma_pkg::*;
#(
    parameter int DW    = DMA_DW,
    parameter int AW    = DMA_AW,
    parameter int BURST = DMA_BURST,
    parameter int PKTS  = 2
) (
    input  logic          c,
    input  logic          rst,
    input  logic [DW-1:0] d,
    input  logic          dv,
    input  logic          de,
    input  logic [AW-1:0] daddr,
    output logic          ready,
    output logic          txs_write,
    output logic [DW-1:0] txs_writedata,
    output logic [5:0]    txs_burstcount,
    output logic [AW-1:0] txs_address,
    input  logic          txs_waitrequest
);
    localparam int RCW = $clog2(BURST + 1);
    localparam int PCW = $clog2(PKTS + 1);

    // Receive side
    logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
    logic [AW-1:0]  rx_addr_q, rx_addr_d;
    logic [PCW-1:0] pkt_count_q, pkt_count_d;
    logic           accept, pkt_close;
    desc_t          desc_in;

    // Transmit side
    tx_state_e      state_q, state_d;
    logic           wr_q, wr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [5:0]     bc_q, bc_d;
    logic [3:0]     rem_q, rem_d;
    logic           load, last_beat, word_pop, desc_pop;

    logic [DW-1:0]  word_rd, word_head;
    desc_t          desc_rd, desc_head;
    logic           word_empty, desc_empty;

    // Slot accounting counts the packet in flight, so ready only gates packet starts.
    assign ready     = (int'(pkt_count_q) + int'(rx_cnt_q != '0)) < PKTS;
    assign accept    = dv && ((rx_cnt_q != '0) || ready);
    assign pkt_close = accept && (de || (rx_cnt_q == RCW'(BURST - 1)));

    // A one-word packet closes on its first word, so take daddr straight from the port.
    assign desc_in.addr = (rx_cnt_q == '0) ? daddr : rx_addr_q;
    assign desc_in.len  = 4'(rx_cnt_q) + 4'd1;

    // Forward the incoming entry when the queue is empty, so a packet closing in the
    // same cycle as a burst's last beat can start back-to-back.
    assign word_head = word_empty ? d : word_rd;
    assign desc_head = desc_empty ? desc_in : desc_rd;

    sync_fifo #(.W(DW), .DEPTH(BURST * PKTS)) u_word_fifo (
        .clk   (c),
        .rst   (rst),
        .push  (accept),
        .wdata (d),
        .pop   (word_pop),
        .rdata (word_rd),
        .empty (word_empty)
    );

    sync_fifo #(.W($bits(desc_t)), .DEPTH(PKTS)) u_desc_fifo (
        .clk   (c),
        .rst   (rst),
        .push  (pkt_close),
        .wdata (desc_in),
        .pop   (desc_pop),
        .rdata (desc_rd),
        .empty (desc_empty)
    );

    // Receive next state: count words, latch the start address on the first word.
    always_comb begin
        rx_cnt_d    = rx_cnt_q;
        rx_addr_d   = rx_addr_q;
        pkt_count_d = pkt_count_q + PCW'(pkt_close) - PCW'(last_beat);
        if (accept) begin
            rx_cnt_d = pkt_close ? '0 : rx_cnt_q + RCW'(1);
            if (rx_cnt_q == '0) rx_addr_d = daddr;
        end
    end

    // Receive-side registers.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            rx_cnt_q    <= '0;
            rx_addr_q   <= '0;
            pkt_count_q <= '0;
        end else begin
            rx_cnt_q    <= rx_cnt_d;
            rx_addr_q   <= rx_addr_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Transmit FSM: load a descriptor, step words on each accepted beat, chain bursts.
    // The descriptor leaves its queue at load; the packet slot is freed at the last beat.
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        bc_d      = bc_q;
        rem_d     = rem_q;
        load      = 1'b0;
        last_beat = 1'b0;
        word_pop  = 1'b0;
        desc_pop  = 1'b0;
        case (state_q)
            TX_IDLE: load = (pkt_count_q != '0);
            TX_BURST: begin
                if (wr_q && !txs_waitrequest) begin
                    if (rem_q > 4'd1) begin
                        wdata_d  = word_head;
                        word_pop = 1'b1;
                        rem_d    = rem_q - 4'd1;
                    end else begin
                        last_beat = 1'b1;
                        if (int'(pkt_count_q) + int'(pkt_close) > 1) begin
                            load = 1'b1;
                        end else begin
                            wr_d    = 1'b0;
                            state_d = TX_IDLE;
                        end
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
        if (load) begin
            state_d  = TX_BURST;
            wr_d     = 1'b1;
            wdata_d  = word_head;
            addr_d   = desc_head.addr;
            bc_d     = {2'b00, desc_head.len};
            rem_d    = desc_head.len;
            word_pop = 1'b1;
            desc_pop = 1'b1;
        end
    end

    // Transmit registers; outputs come straight from flops and hold during a stall.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
            bc_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            bc_q    <= bc_d;
            rem_q   <= rem_d;
        end
    end

    assign txs_write      = wr_q;
    assign txs_writedata  = wdata_q;
    assign txs_address    = addr_q;
    assign txs_burstcount = bc_q;
endmodule

// File: tb/tb_dma_burst_writer.sv
// Bench for dma_burst_writer: packet-level model plus directed literal checks.
module tb_dma_burst_writer;
    logic          c = 1'b0;
    logic          rst;
    logic [127:0]  d;
    logic          dv, de;
    logic [22:0]   daddr;
    logic          ready, txs_write, txs_waitrequest;
    logic [127:0]  txs_writedata;
    logic [5:0]    txs_burstcount;
    logic [22:0]   txs_address;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic wr_force = 1'b0;
    logic wr_rand  = 1'b0;

    typedef struct {
        logic [127:0] dat;
        logic [22:0]  a;
        logic [5:0]   bc;
        bit           last;
    } beat_t;

    // Model state: expected beats, packets closed but not yet fully written,
    // and the packet currently being received.
    beat_t        exp_q[$];
    logic [127:0] stage[$];
    logic [22:0]  cur_addr;
    int           closed = 0, closed_prev = 0, in_words = 0;
    logic         prev_stall = 1'b0;
    logic [127:0] p_d;
    logic [22:0]  p_a;
    logic [5:0]   p_bc;

    // Observed beats for literal checks.
    logic [127:0] log_d[$];
    logic [22:0]  log_a[$];
    logic [5:0]   log_bc[$];
    int           log_cyc[$];

    dma_burst_writer dut (
        .c(c), .rst(rst), .d(d), .dv(dv), .de(de), .daddr(daddr),
        .ready(ready), .txs_write(txs_write), .txs_writedata(txs_writedata),
        .txs_burstcount(txs_burstcount), .txs_address(txs_address),
        .txs_waitrequest(txs_waitrequest)
    );

    initial forever #5 c = ~c;
    initial forever begin @(posedge c); cyc++; end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Slave stall driver.
    initial begin
        txs_waitrequest = 1'b0;
        forever begin
            @(posedge c);
            #2 txs_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : wr_force;
        end
    end

    // Compare process: check outputs against the model, then advance the model
    // with the events the coming edge will commit.
    initial forever begin
        @(negedge c);
        if (rst) begin
            exp_q.delete(); stage.delete();
            closed = 0; closed_prev = 0; in_words = 0; prev_stall = 1'b0;
        end else begin
            automatic bit rdy_exp = (closed + (in_words != 0 ? 1 : 0)) < 2;
            chk("ready", ready, rdy_exp);
            chk("txs_write", txs_write, (closed_prev > 0) && (closed > 0));
            if (prev_stall) begin
                chk("hold_write", txs_write, 1);
                chk("hold_data", txs_writedata, p_d);
                chk("hold_addr", txs_address, p_a);
                chk("hold_bc", txs_burstcount, p_bc);
            end
            prev_stall = txs_write && txs_waitrequest;
            p_d = txs_writedata; p_a = txs_address; p_bc = txs_burstcount;
            closed_prev = closed;
            if (txs_write && !txs_waitrequest) begin
                log_d.push_back(txs_writedata); log_a.push_back(txs_address);
                log_bc.push_back(txs_burstcount); log_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", 1, 0);
                end else begin
                    automatic beat_t e = exp_q.pop_front();
                    chk("beat_data", txs_writedata, e.dat);
                    chk("beat_addr", txs_address, e.a);
                    chk("beat_bc", txs_burstcount, e.bc);
                    if (e.last) closed--;
                end
            end
            if (dv && (in_words != 0 || rdy_exp)) begin
                if (in_words == 0) cur_addr = daddr;
                stage.push_back(d);
                in_words++;
                if (de || in_words == 8) begin
                    for (int j = 0; j < in_words; j++)
                        exp_q.push_back('{dat: stage[j], a: cur_addr, bc: 6'(in_words), last: (j == in_words - 1)});
                    closed++;
                    in_words = 0;
                    stage.delete();
                end
            end
        end
    end

    task automatic clear_log();
        log_d.delete(); log_a.delete(); log_bc.delete(); log_cyc.delete();
    endtask

    // Wait for ready (bounded), then stream n back-to-back words starting at value base.
    task automatic send_pkt(input logic [22:0] a, input int n, input int base);
        int t = 0;
        while (!ready && t < 2000) begin @(posedge c); #1; t++; end
        if (t >= 2000) chk("ready_timeout", ready, 1);
        for (int i = 0; i < n; i++) begin
            dv = 1'b1; d = 128'(base + i); de = (i == n - 1); daddr = a;
            @(posedge c); #1;
        end
        dv = 1'b0; de = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || in_words != 0) && t < 20000) begin @(posedge c); t++; end
        chk("drain_done", exp_q.size(), 0);
        repeat (3) @(posedge c);
        #1;
    endtask

    initial begin
        rst = 1'b1; dv = 1'b0; de = 1'b0; d = '0; daddr = '0;
        repeat (3) @(posedge c);
        #2 rst = 1'b0;
        @(posedge c); #1;
        chk("rst_ready", ready, 1);
        chk("rst_write", txs_write, 0);
        chk("rst_data", txs_writedata, 0);
        chk("rst_addr", txs_address, 0);
        chk("rst_bc", txs_burstcount, 0);
        repeat (20) @(posedge c);
        #1;
        chk("idle_ready", ready, 1);
        chk("idle_write", txs_write, 0);

        // Single full packet, no stalls.
        clear_log();
        send_pkt(23'h10000, 8, 1);
        drain();
        chk("t1_beats", log_d.size(), 8);
        chk("t1_first", log_d[0], 1);
        chk("t1_last", log_d[7], 8);
        chk("t1_addr", log_a[7], 23'h10000);
        chk("t1_bc", log_bc[0], 8);
        chk("t1_contig", log_cyc[7] - log_cyc[0], 7);

        // Two packets behind a long stall, then back-to-back bursts.
        clear_log();
        wr_force = 1'b1;
        send_pkt(23'h10000, 8, 101);
        send_pkt(23'h10080, 8, 201);
        chk("t2_ready_low", ready, 0);
        repeat (40) @(posedge c);
        #1 wr_force = 1'b0;
        drain();
        chk("t2_beats", log_d.size(), 16);
        chk("t2_addr0", log_a[0], 23'h10000);
        chk("t2_addr1", log_a[8], 23'h10080);
        chk("t2_data8", log_d[8], 201);
        chk("t2_data15", log_d[15], 208);
        chk("t2_no_gap", log_cyc[8] - log_cyc[7], 1);
        chk("t2_ready_back", ready, 1);

        // Random stalls over 64 packets.
        clear_log();
        wr_rand = 1'b1;
        for (int k = 0; k < 64; k++) send_pkt(23'(32'h10000 + k * 128), 8, k * 8 + 1);
        drain();
        wr_rand = 1'b0;
        chk("t3_beats", log_d.size(), 512);
        chk("t3_last", log_d[511], 512);
        chk("t3_last_addr", log_a[511], 23'h11F80);

        // Short packet terminated by de.
        clear_log();
        send_pkt(23'h20000, 3, 901);
        drain();
        chk("t4_beats", log_d.size(), 3);
        chk("t4_bc", log_bc[2], 3);
        chk("t4_addr", log_a[0], 23'h20000);
        chk("t4_data", log_d[2], 903);

        // Reset in the middle of a burst.
        begin
            int t = 0;
            send_pkt(23'h30000, 8, 1001);
            while (!txs_write && t < 100) begin @(posedge c); t++; end
            chk("t5_burst_start", txs_write, 1);
            @(posedge c);
            #3 rst = 1'b1;
            #1 chk("t5_async_drop", txs_write, 0);
            @(posedge c);
            #2 rst = 1'b0;
            repeat (2) @(posedge c);
            #1;
            chk("t5_ready", ready, 1);
            chk("t5_write", txs_write, 0);
            clear_log();
            send_pkt(23'h40000, 8, 2001);
            drain();
            chk("t5_beats", log_d.size(), 8);
            chk("t5_addr", log_a[0], 23'h40000);
            chk("t5_data", log_d[0], 2001);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
